// File: rtl/dmr_pkg.sv
// Shared types and defaults for the data-memory responder:
// FSM state encoding, write-buffer entry layout and default sizes.
package dmr_pkg;

   localparam int DMR_AW       = 10;
   localparam int DMR_WB_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      RD_REQ,
      RD_DONE,
      WR_REQ
   } dmr_state_t;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
   } wb_entry_t;

endpackage

// File: rtl/dmr_write_buffer.sv
// Store FIFO for the responder: wrapping pointers with a separate count,
// oldest entry at head, and a newest-match search for load lookups.
module dmr_write_buffer
   import dmr_pkg::*;
#(
   parameter int AW    = DMR_AW,
   parameter int DEPTH = DMR_WB_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [AW-1:0]          push_addr,
   input  logic [31:0]            push_data,
   input  logic                   pop,
   input  logic [AW-1:0]          look_addr,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output wb_entry_t              head,
   output logic                   hit,
   output logic [31:0]            hit_data
);

   localparam int PW = $clog2(DEPTH);

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] idx;

   always_ff @(negedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (push) mem[wr_ptr] <= '{addr: 30'(push_addr), data: push_data};
   end

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Walk oldest to newest so the last match seen is the newest one.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (((PW+1)'(i) < count) && (mem[idx].addr == 30'(look_addr))) begin
            hit      = 1'b1;
            hit_data = mem[idx].data;
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: write buffer in front of a single-port SRAM.
// Define DMR_WB_FORWARD_EN for store-to-load forwarding from the buffer.
module data_mem_responder
   import dmr_pkg::*;
#(
   parameter int AW       = DMR_AW,
   parameter int WB_DEPTH = DMR_WB_DEPTH
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic [31:0]   Addr,
   input  logic [31:0]   WriteData,
   output logic [31:0]   ReadData,
   output logic          ReadValid,
   output logic          Stall,
   output logic          WbEmpty,
   output logic          SramReq,
   output logic          SramWe,
   output logic [AW-1:0] SramAddr,
   output logic [31:0]   SramWData,
   input  logic [31:0]   SramRData,
   input  logic          SramAck
);

   dmr_state_t state;

   logic          req_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   cap_q;
   logic [31:0]   last_q;

   logic [AW-1:0] word;
   logic          push;
   logic          pop;
   logic          wb_full;
   logic          wb_empty;
   logic          wb_hit;
   logic [31:0]   wb_hit_data;
   wb_entry_t     head;
   logic [$clog2(WB_DEPTH):0] wb_count;

   logic          fwd;
   logic          miss;
   logic          rd_done;
   logic          unused_ok;

   assign word      = Addr[AW+1:2];
   assign unused_ok = ^{Addr[1:0], Addr[31:AW+2], wb_count};

   // A simultaneous read drops the write.
   assign push = ~Reset & MemWrite & ~MemRead & ~wb_full;
   assign pop  = ~Reset & (state == WR_REQ) & req_q & SramAck;

   dmr_write_buffer #(
      .AW    (AW),
      .DEPTH (WB_DEPTH)
   ) u_wb (
      .clk       (CLK),
      .rst       (Reset),
      .push      (push),
      .push_addr (word),
      .push_data (WriteData),
      .pop       (pop),
      .look_addr (word),
      .full      (wb_full),
      .empty     (wb_empty),
      .count     (wb_count),
      .head      (head),
      .hit       (wb_hit),
      .hit_data  (wb_hit_data)
   );

`ifdef DMR_WB_FORWARD_EN
   assign fwd = MemRead & wb_hit;
`else
   assign fwd = 1'b0;
`endif

   // Without forwarding, a matching load is neither served nor a miss.
   assign miss    = MemRead & ~wb_hit;
   assign rd_done = MemRead & (state == RD_DONE);

   assign ReadValid = ~Reset & (rd_done | fwd);
   assign ReadData  = Reset   ? '0 :
                      rd_done ? cap_q :
                      fwd     ? wb_hit_data : last_q;

   assign Stall = ~Reset & ((MemRead & ~ReadValid) |
                            (MemWrite & ~MemRead & wb_full));

   assign WbEmpty   = Reset | (wb_empty & (state != WR_REQ));
   assign SramReq   = ~Reset & req_q;
   assign SramWe    = ~Reset & we_q;
   assign SramAddr  = Reset ? '0 : addr_q;
   assign SramWData = Reset ? '0 : wdata_q;

   always_ff @(negedge CLK) begin
      if (Reset) begin
         state   <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cap_q   <= '0;
         last_q  <= '0;
      end else begin
         if (ReadValid) last_q <= ReadData;
         unique case (state)
            IDLE: begin
               if (miss) begin
                  state  <= RD_REQ;
                  req_q  <= 1'b1;
                  we_q   <= 1'b0;
                  addr_q <= word;
               end else if (!wb_empty) begin
                  state   <= WR_REQ;
                  req_q   <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= AW'(head.addr);
                  wdata_q <= head.data;
               end
            end
            RD_REQ: begin
               // Entered straight from a write ack with the request low.
               if (!req_q) begin
                  req_q  <= 1'b1;
                  we_q   <= 1'b0;
                  addr_q <= word;
               end else if (SramAck) begin
                  req_q <= 1'b0;
                  cap_q <= SramRData;
                  state <= RD_DONE;
               end
            end
            RD_DONE: begin
               state <= IDLE;
            end
            WR_REQ: begin
               if (SramAck) begin
                  req_q <= 1'b0;
                  we_q  <= 1'b0;
                  state <= miss ? RD_REQ : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a small SRAM model
// (auto-ack with programmable latency, or manual ack from the tests).
module tb_data_mem_responder;

   logic        CLK;
   logic        Reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        ReadValid;
   logic        Stall;
   logic        WbEmpty;
   logic        SramReq;
   logic        SramWe;
   logic [9:0]  SramAddr;
   logic [31:0] SramWData;
   logic [31:0] SramRData;
   logic        SramAck;

   int errors = 0;
   int checks = 0;

   logic [31:0] smem [1024];
   bit          auto_ack;
   int          lat;
   int          cnt;

   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t wlog[$];

   data_mem_responder dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Addr      (Addr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .ReadValid (ReadValid),
      .Stall     (Stall),
      .WbEmpty   (WbEmpty),
      .SramReq   (SramReq),
      .SramWe    (SramWe),
      .SramAddr  (SramAddr),
      .SramWData (SramWData),
      .SramRData (SramRData),
      .SramAck   (SramAck)
   );

   initial CLK = 1'b1;
   always #5 CLK = ~CLK;

   // SRAM model: acks lat cycles after the request is first seen.
   always @(posedge CLK) begin
      if (Reset) begin
         cnt = 0;
         if (auto_ack) SramAck = 1'b0;
      end else if (auto_ack) begin
         if (SramAck) begin
            SramAck = 1'b0;
            cnt = 0;
         end else if (SramReq) begin
            if (cnt >= lat) begin
               SramAck = 1'b1;
               if (!SramWe) SramRData = smem[SramAddr];
            end else begin
               cnt++;
            end
         end
      end
   end

   always @(posedge CLK) begin
      #2;
      if (!Reset && SramReq && SramAck && SramWe) begin
         wlog.push_back('{SramAddr, SramWData});
         smem[SramAddr] = SramWData;
      end
   end

   task automatic mid();
      @(posedge CLK);
      #2;
   endtask

   task automatic nxt();
      @(negedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h40;
      nxt(); mid();
      checks++;
      if (Stall !== 1'b0 || ReadValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall_rv: got %b%b want 00", Stall, ReadValid);
      end
      checks++;
      if ({SramReq, SramWe, SramAddr, SramWData, ReadData} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b we=%b a=%h wd=%h rd=%h want 0",
                  SramReq, SramWe, SramAddr, SramWData, ReadData);
      end
      checks++;
      if (WbEmpty !== 1'b1) begin
         errors++;
         $display("FAIL reset_wbempty: got %b want 1", WbEmpty);
      end
      nxt(); Reset = 1'b0; MemRead = 1'b0; mid();
      checks++;
      if (WbEmpty !== 1'b1 || SramReq !== 1'b0 || Stall !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: wbe=%b req=%b stall=%b want 1 0 0",
                  WbEmpty, SramReq, Stall);
      end
   endtask

   task automatic test_forward();
      int n;
      wlog.delete(); lat = 1;
      nxt(); MemWrite = 1'b1; Addr = 32'h40; WriteData = 32'h11; mid();
      checks++;
      if (Stall !== 1'b0) begin
         errors++; $display("FAIL fwd_store1: stall=%b want 0", Stall);
      end
      nxt(); WriteData = 32'h22; mid();
      checks++;
      if (Stall !== 1'b0) begin
         errors++; $display("FAIL fwd_store2: stall=%b want 0", Stall);
      end
      nxt(); MemWrite = 1'b0; MemRead = 1'b1; mid();
`ifdef DMR_WB_FORWARD_EN
      checks++;
      if (ReadValid !== 1'b1 || Stall !== 1'b0 || ReadData !== 32'h22) begin
         errors++;
         $display("FAIL fwd_hit: rv=%b stall=%b rd=%h want 1 0 00000022",
                  ReadValid, Stall, ReadData);
      end
`else
      checks++;
      if (Stall !== 1'b1) begin
         errors++; $display("FAIL fwd_block: stall=%b want 1", Stall);
      end
      n = 0;
      while (!ReadValid && n < 40) begin
         nxt(); mid(); n++;
      end
      checks++;
      if (ReadValid !== 1'b1 || ReadData !== 32'h22 || WbEmpty !== 1'b1) begin
         errors++;
         $display("FAIL fwd_drained_load: rv=%b rd=%h wbe=%b want 1 00000022 1",
                  ReadValid, ReadData, WbEmpty);
      end
      checks++;
      if (wlog.size() != 2) begin
         errors++; $display("FAIL fwd_drain_cnt: got %0d want 2", wlog.size());
      end else if (wlog[0].d !== 32'h11 || wlog[1].d !== 32'h22) begin
         errors++;
         $display("FAIL fwd_drain_order: got %h %h want 11 22",
                  wlog[0].d, wlog[1].d);
      end
`endif
      nxt(); MemRead = 1'b0; mid();
      checks++;
      if (ReadValid !== 1'b0 || ReadData !== 32'h22) begin
         errors++;
         $display("FAIL fwd_hold: rv=%b rd=%h want 0 00000022", ReadValid, ReadData);
      end
      n = 0;
      while (!WbEmpty && n < 40) begin
         nxt(); mid(); n++;
      end
      checks++;
      if (WbEmpty !== 1'b1) begin
         errors++; $display("FAIL fwd_drain_timeout: wbe=%b want 1", WbEmpty);
      end
   endtask

   task automatic test_miss();
      int stalls;
      lat = 3; smem[10'h20] = 32'hDEADBEEF;
      nxt(); MemRead = 1'b1; Addr = 32'h80; mid();
      stalls = 0;
      for (int i = 0; i < 20 && !ReadValid; i++) begin
         if (Stall) stalls++;
         if (i == 1) begin
            checks++;
            if (SramReq !== 1'b1 || SramWe !== 1'b0 || SramAddr !== 10'h20) begin
               errors++;
               $display("FAIL miss_req: req=%b we=%b a=%h want 1 0 020",
                        SramReq, SramWe, SramAddr);
            end
         end
         nxt(); mid();
      end
      checks++;
      if (stalls != 5) begin
         errors++; $display("FAIL miss_stall_cycles: got %0d want 5", stalls);
      end
      checks++;
      if (ReadValid !== 1'b1 || ReadData !== 32'hDEADBEEF || Stall !== 1'b0) begin
         errors++;
         $display("FAIL miss_data: rv=%b rd=%h stall=%b want 1 deadbeef 0",
                  ReadValid, ReadData, Stall);
      end
      nxt(); MemRead = 1'b0; lat = 1; mid();
      checks++;
      if (ReadValid !== 1'b0) begin
         errors++; $display("FAIL miss_rv_drop: rv=%b want 0", ReadValid);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      nxt(); auto_ack = 1'b0; SramAck = 1'b0; cnt = 0; wlog.delete();
      for (int i = 0; i < 4; i++) begin
         MemWrite = 1'b1; Addr = 32'h100 + 32'(4 * i); WriteData = 32'hA0 + 32'(i);
         mid();
         checks++;
         if (Stall !== 1'b0) begin
            errors++; $display("FAIL b2b_accept%0d: stall=%b want 0", i, Stall);
         end
         nxt();
      end
      Addr = 32'h110; WriteData = 32'hA4; mid();
      checks++;
      if (Stall !== 1'b1) begin
         errors++; $display("FAIL b2b_full: stall=%b want 1", Stall);
      end
      nxt(); mid();
      checks++;
      if (Stall !== 1'b1) begin
         errors++; $display("FAIL b2b_full_hold: stall=%b want 1", Stall);
      end
      nxt(); SramAck = 1'b1; mid();
      checks++;
      if (Stall !== 1'b1) begin
         errors++; $display("FAIL b2b_pop_cycle: stall=%b want 1", Stall);
      end
      checks++;
      if (SramWe !== 1'b1 || SramAddr !== 10'h40 || SramWData !== 32'hA0) begin
         errors++;
         $display("FAIL b2b_head: we=%b a=%h wd=%h want 1 040 000000a0",
                  SramWe, SramAddr, SramWData);
      end
      nxt(); SramAck = 1'b0; mid();
      checks++;
      if (Stall !== 1'b0) begin
         errors++; $display("FAIL b2b_after_pop: stall=%b want 0", Stall);
      end
      nxt(); MemWrite = 1'b0; cnt = 0; lat = 0; auto_ack = 1'b1; mid();
      n = 0;
      while (!WbEmpty && n < 60) begin
         nxt(); mid(); n++;
      end
      checks++;
      if (wlog.size() != 5) begin
         errors++; $display("FAIL b2b_drain_cnt: got %0d want 5", wlog.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog[i].a !== 10'h40 + 10'(i) || wlog[i].d !== 32'hA0 + 32'(i)) begin
               errors++;
               $display("FAIL b2b_order%0d: got %h/%h want %h/%h", i, wlog[i].a,
                        wlog[i].d, 10'h40 + 10'(i), 32'hA0 + 32'(i));
            end
         end
      end
      lat = 1;
   endtask

   task automatic test_miss_during_drain();
      int  n;
      bit  early;
      lat = 2; wlog.delete(); smem[10'hC0] = 32'h5A5A0003;
      nxt(); MemWrite = 1'b1; Addr = 32'h200; WriteData = 32'hB1; mid();
      nxt(); Addr = 32'h204; WriteData = 32'hB2; mid();
      nxt(); MemWrite = 1'b0; MemRead = 1'b1; Addr = 32'h300; mid();
      checks++;
      if (Stall !== 1'b1 || SramReq !== 1'b1 || SramWe !== 1'b1) begin
         errors++;
         $display("FAIL mdd_inflight: stall=%b req=%b we=%b want 1 1 1",
                  Stall, SramReq, SramWe);
      end
      early = 1'b0; n = 0;
      while (!ReadValid && n < 30) begin
         if (SramReq && !SramWe && wlog.size() == 0) early = 1'b1;
         nxt(); mid(); n++;
      end
      checks++;
      if (early) begin
         errors++; $display("FAIL mdd_read_before_ack: early=1 want 0");
      end
      checks++;
      if (ReadValid !== 1'b1 || ReadData !== 32'h5A5A0003) begin
         errors++;
         $display("FAIL mdd_load: rv=%b rd=%h want 1 5a5a0003", ReadValid, ReadData);
      end
      checks++;
      if (wlog.size() != 1 || wlog[0].a !== 10'h80 || wlog[0].d !== 32'hB1) begin
         errors++;
         $display("FAIL mdd_first_write: n=%0d want 1 write 080/b1", wlog.size());
      end
      nxt(); MemRead = 1'b0; mid();
      n = 0;
      while (!WbEmpty && n < 40) begin
         nxt(); mid(); n++;
      end
      checks++;
      if (WbEmpty !== 1'b1 || wlog.size() != 2) begin
         errors++;
         $display("FAIL mdd_drain: wbe=%b n=%0d want 1 2", WbEmpty, wlog.size());
      end else if (wlog[1].a !== 10'h81 || wlog[1].d !== 32'hB2) begin
         errors++;
         $display("FAIL mdd_order: got %h/%h want 081/b2", wlog[1].a, wlog[1].d);
      end
      lat = 1;
   endtask

   task automatic test_illegal();
      int n;
      bit wbe_drop;
      smem[10'h4] = 32'h12345678; wlog.delete();
      nxt(); MemRead = 1'b1; MemWrite = 1'b1; Addr = 32'h10; WriteData = 32'h99;
      mid();
      n = 0; wbe_drop = 1'b0;
      while (!ReadValid && n < 20) begin
         if (!WbEmpty) wbe_drop = 1'b1;
         nxt(); mid(); n++;
      end
      checks++;
      if (ReadValid !== 1'b1 || ReadData !== 32'h12345678) begin
         errors++;
         $display("FAIL ill_load: rv=%b rd=%h want 1 12345678", ReadValid, ReadData);
      end
      checks++;
      if (wbe_drop || WbEmpty !== 1'b1) begin
         errors++; $display("FAIL ill_no_entry: wbe=%b dropped=%b want 1 0",
                            WbEmpty, wbe_drop);
      end
      nxt(); MemRead = 1'b0; MemWrite = 1'b0; mid();
      nxt(); mid();
      checks++;
      if (wlog.size() != 0 || SramReq !== 1'b0) begin
         errors++;
         $display("FAIL ill_no_write: n=%0d req=%b want 0 0", wlog.size(), SramReq);
      end
      nxt(); MemRead = 1'b1; mid();
      n = 0;
      while (!ReadValid && n < 20) begin
         nxt(); mid(); n++;
      end
      checks++;
      if (ReadValid !== 1'b1 || ReadData !== 32'h12345678) begin
         errors++;
         $display("FAIL ill_reload: rv=%b rd=%h want 1 12345678", ReadValid, ReadData);
      end
      nxt(); MemRead = 1'b0; mid();
   endtask

   task automatic test_reset_mid();
      nxt(); auto_ack = 1'b0; SramAck = 1'b0; cnt = 0; wlog.delete();
      MemWrite = 1'b1; Addr = 32'h200; WriteData = 32'hC1; mid();
      nxt(); Addr = 32'h204; WriteData = 32'hC2; mid();
      nxt(); Addr = 32'h208; WriteData = 32'hC3; mid();
      nxt(); MemWrite = 1'b0; MemRead = 1'b1; Addr = 32'h300; SramAck = 1'b1; mid();
      checks++;
      if (Stall !== 1'b1 || SramWe !== 1'b1) begin
         errors++;
         $display("FAIL rm_pre: stall=%b we=%b want 1 1", Stall, SramWe);
      end
      nxt(); SramAck = 1'b0; Reset = 1'b1; mid();
      checks++;
      if (SramReq !== 1'b0 || Stall !== 1'b0 || ReadValid !== 1'b0 ||
          WbEmpty !== 1'b1) begin
         errors++;
         $display("FAIL rm_during: req=%b stall=%b rv=%b wbe=%b want 0 0 0 1",
                  SramReq, Stall, ReadValid, WbEmpty);
      end
      nxt(); Reset = 1'b0; MemRead = 1'b0; mid();
      checks++;
      if (SramReq !== 1'b0 || Stall !== 1'b0 || ReadValid !== 1'b0 ||
          WbEmpty !== 1'b1) begin
         errors++;
         $display("FAIL rm_after: req=%b stall=%b rv=%b wbe=%b want 0 0 0 1",
                  SramReq, Stall, ReadValid, WbEmpty);
      end
      nxt(); mid();
      checks++;
      if (SramReq !== 1'b0 || WbEmpty !== 1'b1) begin
         errors++;
         $display("FAIL rm_discard: req=%b wbe=%b want 0 1", SramReq, WbEmpty);
      end
      auto_ack = 1'b1; cnt = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) smem[i] = '0;
      Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
      Addr = '0; WriteData = '0; SramRData = '0; SramAck = 1'b0;
      auto_ack = 1'b1; lat = 1; cnt = 0;
      test_reset();
      test_forward();
      test_miss();
      test_back_to_back();
      test_miss_during_drain();
      test_illegal();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
